pipe_mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipeline's instruction-fetch stage and its MEM stage (load/store).
- Accepts requests from both requesters and serializes them onto the memory port with a req/ack/rvalid handshake.
- Returns read data to each requester and generates the IF and MEM stall signals.
- Serves each requester at most once per pipeline advance, and flags a memory timeout.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_timeout.sv | 39 +++
 rtl/pipe_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the pipeline memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_timeout.sv
// Transaction watchdog: counts cycles while enabled, flags the last allowed cycle.
module mem_arb_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage.
module pipe_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [1:0]  FETCH_SIZE = SZ_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PIPE_ADV,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_RDATA,
    output logic        IF_READY,
    output logic        STALL_IF,
    input  logic        D_RD,
    input  logic        D_WR,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    input  logic        D_SIGN,
    output logic [31:0] D_RDATA,
    output logic        D_READY,
    output logic        STALL_D,
    output logic        M_REQ,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [1:0]  M_SIZE,
    output logic        M_SIGN,
    input  logic        M_ACK,
    input  logic        M_RVALID,
    input  logic [31:0] M_RDATA,
    output logic        ERR
);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [1:0]  m_size_q, m_size_d;
    logic        m_sign_q, m_sign_d;
    logic        if_served_q, if_served_d;
    logic        d_served_q, d_served_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;
    logic        busy;
    logic        expired;
    logic        d_pend;

    assign busy   = (state_q == REQ) || (state_q == WAIT);
    assign d_pend = (D_RD || D_WR) && !d_served_q;

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (!busy),
        .en_i      (busy),
        .expired_o (expired)
    );

    // Next-state, request latching, read capture and served-flag bookkeeping.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_size_d    = m_size_q;
        m_sign_d    = m_sign_q;
        if_served_d = if_served_q;
        d_served_d  = d_served_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (d_pend) begin
                    owner_d   = OWN_D;
                    m_we_d    = D_WR;
                    m_addr_d  = D_ADDR;
                    m_wdata_d = D_WDATA;
                    m_size_d  = D_SIZE;
                    m_sign_d  = D_SIGN;
                    state_d   = REQ;
                end else if (IF_REQ && !if_served_q) begin
                    owner_d  = OWN_IF;
                    m_we_d   = 1'b0;
                    m_addr_d = IF_ADDR;
                    m_size_d = FETCH_SIZE;
                    m_sign_d = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ, WAIT: begin
                if ((state_q == REQ) && M_ACK) begin
                    state_d = m_we_q ? RESP : WAIT;
                end else if ((state_q == WAIT) && M_RVALID) begin
                    if (owner_q == OWN_D) d_rdata_d  = M_RDATA;
                    else                  if_rdata_d = M_RDATA;
                    state_d = RESP;
                end else if (expired) begin
                    err_d = 1'b1;
                    if (owner_q == OWN_D) d_rdata_d  = '0;
                    else                  if_rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == OWN_D) d_served_d  = 1'b1;
                else                  if_served_d = 1'b1;
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pipeline advance clears both flags, even over a same-cycle completion.
        if (PIPE_ADV) begin
            if_served_d = 1'b0;
            d_served_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_size_q    <= '0;
            m_sign_q    <= 1'b0;
            if_served_q <= 1'b0;
            d_served_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_size_q    <= m_size_d;
            m_sign_q    <= m_sign_d;
            if_served_q <= if_served_d;
            d_served_q  <= d_served_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign M_REQ    = (state_q == REQ);
    assign M_WE     = m_we_q;
    assign M_ADDR   = m_addr_q;
    assign M_WDATA  = m_wdata_q;
    assign M_SIZE   = m_size_q;
    assign M_SIGN   = m_sign_q;
    assign IF_RDATA = if_rdata_q;
    assign D_RDATA  = d_rdata_q;
    assign IF_READY = if_served_q;
    assign D_READY  = d_served_q;
    assign ERR      = err_q;
    assign STALL_IF = IF_REQ && !if_served_q;
    assign STALL_D  = (D_RD || D_WR) && !d_served_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: directed scenarios plus randomized contention.
module tb_pipe_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } txn_t;

    logic        CLK = 1'b0;
    logic        RST, PIPE_ADV, IF_REQ, D_RD, D_WR, D_SIGN;
    logic [31:0] IF_ADDR, D_ADDR, D_WDATA;
    logic [1:0]  D_SIZE;
    logic [31:0] IF_RDATA, D_RDATA, M_ADDR, M_WDATA, M_RDATA;
    logic        IF_READY, STALL_IF, D_READY, STALL_D, M_REQ, M_WE, M_SIGN, M_ACK, M_RVALID, ERR;
    logic [1:0]  M_SIZE;

    // Memory-side drivers: automatic responder or directed manual control.
    logic        auto_en = 1'b0;
    logic        ack_a = 1'b0, rv_a = 1'b0, ack_m = 1'b0, rv_m = 1'b0;
    logic [31:0] rdata_a = '0, rdata_m = '0;
    assign M_ACK    = auto_en ? ack_a : ack_m;
    assign M_RVALID = auto_en ? rv_a : rv_m;
    assign M_RDATA  = auto_en ? rdata_a : rdata_m;

    int checks = 0;
    int errors = 0;

    txn_t        obs_q[$];
    logic [31:0] resp_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    always #5 CLK = ~CLK;

    pipe_mem_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .CLK(CLK), .RST(RST), .PIPE_ADV(PIPE_ADV),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_READY(IF_READY), .STALL_IF(STALL_IF),
        .D_RD(D_RD), .D_WR(D_WR), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_SIZE(D_SIZE), .D_SIGN(D_SIGN),
        .D_RDATA(D_RDATA), .D_READY(D_READY), .STALL_D(STALL_D),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_SIZE(M_SIZE), .M_SIGN(M_SIGN),
        .M_ACK(M_ACK), .M_RVALID(M_RVALID), .M_RDATA(M_RDATA), .ERR(ERR)
    );

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    // Memory model: acks after 0-1 cycles, returns read data 0-1 cycles later.
    initial begin
        txn_t t;
        int unsigned ack_dly, rv_dly;
        forever begin
            @(negedge CLK);
            if (auto_en && M_REQ) begin
                t = '{we: M_WE, addr: M_ADDR, wdata: M_WDATA, size: M_SIZE, sign: M_SIGN};
                ack_dly = $urandom_range(0, 1);
                rv_dly  = $urandom_range(0, 1);
                for (int unsigned i = 0; i < ack_dly; i++) begin
                    @(negedge CLK);
                    checks++;
                    if (M_REQ !== 1'b1 || M_ADDR !== t.addr || M_WE !== t.we || M_SIZE !== t.size) begin
                        errors++;
                        $display("FAIL req_stable: M_REQ=%b M_ADDR=%h expected held request addr %h", M_REQ, M_ADDR, t.addr);
                    end
                end
                ack_a = 1'b1;
                obs_q.push_back(t);
                @(negedge CLK);
                ack_a = 1'b0;
                if (t.we) begin
                    resp_mem[t.addr] = t.wdata;
                end else begin
                    for (int unsigned i = 0; i < rv_dly; i++) @(negedge CLK);
                    rv_a    = 1'b1;
                    rdata_a = resp_mem.exists(t.addr) ? resp_mem[t.addr] : mem_init(t.addr);
                    @(negedge CLK);
                    rv_a = 1'b0;
                end
            end
        end
    end

    task automatic drop_inputs();
        IF_REQ = 1'b0; D_RD = 1'b0; D_WR = 1'b0;
        IF_ADDR = '0; D_ADDR = '0; D_WDATA = '0; D_SIZE = '0; D_SIGN = 1'b0;
    endtask

    task automatic advance();
        PIPE_ADV = 1'b1;
        drop_inputs();
        @(negedge CLK);
        PIPE_ADV = 1'b0;
        checks++;
        if (IF_READY !== 1'b0 || D_READY !== 1'b0) begin
            errors++;
            $display("FAIL adv_clear: IF_READY=%b D_READY=%b expected 0 0", IF_READY, D_READY);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; PIPE_ADV = 1'b0;
        drop_inputs();
        repeat (3) @(negedge CLK);
        checks++;
        if ({M_REQ, M_WE, ERR, IF_READY, D_READY, STALL_IF, STALL_D} !== 7'b0 ||
            IF_RDATA !== 32'h0 || D_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset: M_REQ=%b M_WE=%b ERR=%b IF_READY=%b D_READY=%b IF_RDATA=%h D_RDATA=%h expected all 0",
                     M_REQ, M_WE, ERR, IF_READY, D_READY, IF_RDATA, D_RDATA);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_fetch();
        IF_REQ = 1'b1; IF_ADDR = 32'h100;
        @(negedge CLK);
        checks++;
        if (M_REQ !== 1'b1 || M_ADDR !== 32'h100 || M_SIZE !== 2'b10 || M_WE !== 1'b0 || M_SIGN !== 1'b0) begin
            errors++;
            $display("FAIL fetch_req: M_REQ=%b M_ADDR=%h M_SIZE=%b M_WE=%b expected 1 00000100 10 0", M_REQ, M_ADDR, M_SIZE, M_WE);
        end
        ack_m = 1'b1;
        @(negedge CLK);
        ack_m = 1'b0;
        checks++;
        if (M_REQ !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait_req: M_REQ=%b expected 0", M_REQ);
        end
        rv_m = 1'b1; rdata_m = 32'h00500093;
        @(negedge CLK);
        rv_m = 1'b0; rdata_m = '0;
        checks++;
        if (IF_READY !== 1'b0 || STALL_IF !== 1'b1) begin
            errors++;
            $display("FAIL fetch_early: IF_READY=%b STALL_IF=%b expected 0 1", IF_READY, STALL_IF);
        end
        @(negedge CLK);
        checks++;
        if (IF_READY !== 1'b1 || STALL_IF !== 1'b0 || IF_RDATA !== 32'h00500093) begin
            errors++;
            $display("FAIL fetch_done: IF_READY=%b STALL_IF=%b IF_RDATA=%h expected 1 0 00500093", IF_READY, STALL_IF, IF_RDATA);
        end
        @(negedge CLK);
        checks++;
        if (M_REQ !== 1'b0 || IF_READY !== 1'b1) begin
            errors++;
            $display("FAIL fetch_hold: M_REQ=%b IF_READY=%b expected 0 1", M_REQ, IF_READY);
        end
        advance();
    endtask

    task automatic test_store();
        D_WR = 1'b1; D_ADDR = 32'h2004; D_WDATA = 32'h12345678; D_SIZE = 2'b01; D_SIGN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (M_REQ !== 1'b1 || M_WE !== 1'b1 || M_ADDR !== 32'h2004 || M_WDATA !== 32'h12345678 || M_SIZE !== 2'b01) begin
                errors++;
                $display("FAIL store_req[%0d]: M_REQ=%b M_WE=%b M_ADDR=%h M_WDATA=%h M_SIZE=%b expected 1 1 00002004 12345678 01",
                         i, M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE);
            end
            if (i == 2) ack_m = 1'b1;
        end
        @(negedge CLK);
        ack_m = 1'b0;
        checks++;
        if (M_REQ !== 1'b0 || D_READY !== 1'b0 || STALL_D !== 1'b1) begin
            errors++;
            $display("FAIL store_resp: M_REQ=%b D_READY=%b STALL_D=%b expected 0 0 1", M_REQ, D_READY, STALL_D);
        end
        @(negedge CLK);
        checks++;
        if (D_READY !== 1'b1 || STALL_D !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL store_done: D_READY=%b STALL_D=%b ERR=%b expected 1 0 0", D_READY, STALL_D, ERR);
        end
        ref_mem[32'h2004] = 32'h12345678;
        resp_mem[32'h2004] = 32'h12345678;
        advance();
    endtask

    // Random steps: each step is one pipeline slot with an optional fetch and optional data access.
    task automatic test_contention_random(input int steps);
        txn_t exp_q[$];
        int unsigned d_op;
        logic        if_req;
        int          c;
        auto_en = 1'b1;
        for (int s = 0; s < steps; s++) begin
            exp_q.delete();
            obs_q.delete();
            if_req  = ($urandom_range(0, 3) != 0);
            d_op    = $urandom_range(0, 3);
            if (!if_req && d_op == 0) if_req = 1'b1;
            IF_REQ  = if_req;
            IF_ADDR = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            D_RD    = (d_op == 1) || (d_op == 3);
            D_WR    = (d_op == 2) || (d_op == 3);
            D_ADDR  = 32'h2000 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            D_WDATA = $urandom;
            D_SIZE  = 2'($urandom_range(0, 2));
            D_SIGN  = 1'($urandom_range(0, 1));
            if (d_op != 0)
                exp_q.push_back('{we: D_WR, addr: D_ADDR, wdata: D_WDATA, size: D_SIZE, sign: D_SIGN});
            if (if_req)
                exp_q.push_back('{we: 1'b0, addr: IF_ADDR, wdata: 32'h0, size: 2'b10, sign: 1'b0});
            c = 0;
            @(negedge CLK);
            while ((STALL_IF || STALL_D) && c < 40) begin
                @(negedge CLK);
                c++;
            end
            checks++;
            if (STALL_IF || STALL_D) begin
                errors++;
                $display("FAIL rand_timeout[%0d]: STALL_IF=%b STALL_D=%b still set after 40 cycles", s, STALL_IF, STALL_D);
            end
            repeat (3) @(negedge CLK);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_txn_count[%0d]: got %0d memory requests expected %0d", s, obs_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    checks++;
                    if (obs_q[k].we !== exp_q[k].we || obs_q[k].addr !== exp_q[k].addr || obs_q[k].size !== exp_q[k].size ||
                        obs_q[k].sign !== exp_q[k].sign || (exp_q[k].we && obs_q[k].wdata !== exp_q[k].wdata)) begin
                        errors++;
                        $display("FAIL rand_txn[%0d.%0d]: got we=%b addr=%h size=%b sign=%b expected we=%b addr=%h size=%b sign=%b",
                                 s, k, obs_q[k].we, obs_q[k].addr, obs_q[k].size, obs_q[k].sign,
                                 exp_q[k].we, exp_q[k].addr, exp_q[k].size, exp_q[k].sign);
                    end
                end
            end
            checks++;
            if (IF_READY !== if_req || D_READY !== (d_op != 0) || ERR !== 1'b0) begin
                errors++;
                $display("FAIL rand_ready[%0d]: IF_READY=%b D_READY=%b ERR=%b expected %b %b 0", s, IF_READY, D_READY, ERR, if_req, d_op != 0);
            end
            if (d_op == 1) begin
                checks++;
                if (D_RDATA !== (ref_mem.exists(D_ADDR) ? ref_mem[D_ADDR] : mem_init(D_ADDR))) begin
                    errors++;
                    $display("FAIL rand_load[%0d]: D_RDATA=%h expected %h", s, D_RDATA,
                             ref_mem.exists(D_ADDR) ? ref_mem[D_ADDR] : mem_init(D_ADDR));
                end
            end else if (d_op != 0) begin
                ref_mem[D_ADDR] = D_WDATA;
            end
            if (if_req) begin
                checks++;
                if (IF_RDATA !== (ref_mem.exists(IF_ADDR) ? ref_mem[IF_ADDR] : mem_init(IF_ADDR))) begin
                    errors++;
                    $display("FAIL rand_fetch[%0d]: IF_RDATA=%h expected %h", s, IF_RDATA, mem_init(IF_ADDR));
                end
            end
            advance();
        end
        auto_en = 1'b0;
    endtask

    task automatic test_timeout();
        int c;
        D_RD = 1'b1; D_ADDR = 32'h3000; D_SIZE = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (M_REQ !== 1'b1 || ERR !== 1'b0) begin
                errors++;
                $display("FAIL to_req[%0d]: M_REQ=%b ERR=%b expected 1 0", i, M_REQ, ERR);
            end
        end
        @(negedge CLK);
        checks++;
        if (M_REQ !== 1'b0 || ERR !== 1'b1 || D_READY !== 1'b0) begin
            errors++;
            $display("FAIL to_abort: M_REQ=%b ERR=%b D_READY=%b expected 0 1 0", M_REQ, ERR, D_READY);
        end
        @(negedge CLK);
        checks++;
        if (D_READY !== 1'b1 || D_RDATA !== 32'h0 || STALL_D !== 1'b0) begin
            errors++;
            $display("FAIL to_release: D_READY=%b D_RDATA=%h STALL_D=%b expected 1 00000000 0", D_READY, D_RDATA, STALL_D);
        end
        advance();
        auto_en = 1'b1;
        IF_REQ = 1'b1; IF_ADDR = 32'h40;
        c = 0;
        @(negedge CLK);
        while (STALL_IF && c < 40) begin
            @(negedge CLK);
            c++;
        end
        checks++;
        if (STALL_IF !== 1'b0 || ERR !== 1'b1 || IF_RDATA !== mem_init(32'h40)) begin
            errors++;
            $display("FAIL to_sticky: STALL_IF=%b ERR=%b IF_RDATA=%h expected 0 1 %h", STALL_IF, ERR, IF_RDATA, mem_init(32'h40));
        end
        advance();
        repeat (4) @(negedge CLK);
        auto_en = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        D_RD = 1'b1; D_ADDR = 32'h2008; D_SIZE = 2'b10;
        @(negedge CLK);
        ack_m = 1'b1;
        @(negedge CLK);
        ack_m = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        drop_inputs();
        checks++;
        if (M_REQ !== 1'b0 || D_READY !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait: M_REQ=%b D_READY=%b ERR=%b expected 0 0 0", M_REQ, D_READY, ERR);
        end
        rv_m = 1'b1; rdata_m = 32'hDEADBEEF;
        @(negedge CLK);
        rv_m = 1'b0; rdata_m = '0;
        @(negedge CLK);
        checks++;
        if (M_REQ !== 1'b0 || D_READY !== 1'b0 || D_RDATA !== 32'h0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_rvalid: M_REQ=%b D_READY=%b D_RDATA=%h ERR=%b expected 0 0 00000000 0", M_REQ, D_READY, D_RDATA, ERR);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention_random(40);
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
